sl5: RTL and testbench

- Registered logical-shift-left-by-5 unit for the datapath, e.g. for building wide immediates and addresses.
- Accepts an N-bit word over a valid/ready handshake and returns the word shifted left by 5 with zero fill; the 5 MSBs shifted out are discarded from the result.
- The bits shifted out are also reported, together with overflow and zero status.

---
 rtl/sl5.sv | 76 +++++++
 tb/tb_sl5.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sl5.sv
// sl5: registered logical shift-left-by-5 with valid/ready handshake.
// One result register stage; a new word may be accepted in the same cycle the
// held result drains, giving one word per clock.
// Optional: define SL5_STICKY_OVF_EN to add the ovf_sticky / ovf_clr ports.
module sl5 #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] num,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] num32,
  output logic [4:0]   dropped,
  output logic         ovf,
  output logic         zero
`ifdef SL5_STICKY_OVF_EN
  ,
  output logic         ovf_sticky,
  input  logic         ovf_clr
`endif
);

  typedef struct packed {
    logic [N-1:0] num32;
    logic [4:0]   dropped;
    logic         ovf;
    logic         zero;
  } rsp_t;

  rsp_t rsp_d, rsp_q;
  logic accept;

  // Stage is free when empty or when its content leaves this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Result fields computed from the operand; only reach outputs via rsp_q.
  always_comb begin
    rsp_d         = '0;
    rsp_d.num32   = {num[N-6:0], 5'b00000};
    rsp_d.dropped = num[N-1:N-5];
    rsp_d.ovf     = |num[N-1:N-5];
    rsp_d.zero    = ~|num[N-6:0];
  end

  // Valid flag: set on accept, cleared when drained with nothing new behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         out_valid <= 1'b0;
    else if (accept)    out_valid <= 1'b1;
    else if (out_ready) out_valid <= 1'b0;
  end

  // Result register: loads only on accept, otherwise holds (stable under backpressure).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rsp_q <= '0;
    else if (accept) rsp_q <= rsp_d;
  end

  assign num32   = rsp_q.num32;
  assign dropped = rsp_q.dropped;
  assign ovf     = rsp_q.ovf;
  assign zero    = rsp_q.zero;

`ifdef SL5_STICKY_OVF_EN
  // Sticky overflow: set by any overflowing accept, which beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  ovf_sticky <= 1'b0;
    else if (accept && rsp_d.ovf) ovf_sticky <= 1'b1;
    else if (ovf_clr)            ovf_sticky <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_sl5.sv
// Self-checking bench for sl5: directed tables, backpressure, async reset and
// random handshake traffic against a one-entry buffer reference model.
module tb_sl5;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] num = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] num32;
  logic [4:0]   dropped;
  logic         ovf;
  logic         zero;
  logic         ovf_sticky;
  logic         ovf_clr = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state
  bit           m_valid = 0;
  logic [N-1:0] m_num32 = '0;
  logic [4:0]   m_dropped = '0;
  bit           m_ovf = 0;
  bit           m_zero = 0;
  bit           m_sticky = 0;
  logic [N-1:0] q[$];

  always #5 clk = ~clk;

  sl5 #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .num(num),
    .out_valid(out_valid), .out_ready(out_ready),
    .num32(num32), .dropped(dropped), .ovf(ovf), .zero(zero)
`ifdef SL5_STICKY_OVF_EN
    , .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
`endif
  );

`ifndef SL5_STICKY_OVF_EN
  assign ovf_sticky = 1'b0;
`endif

  function automatic logic [N-1:0] f_shift(logic [N-1:0] n);
    longint unsigned v;
    v = longint'(n) * 32;
    return N'(v % (64'd1 << N));
  endfunction

  function automatic logic [4:0] f_drop(logic [N-1:0] n);
    return 5'(longint'(n) / (64'd1 << (N - 5)));
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(string tag);
    check({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
    check({tag, ".num32"},     64'(num32),     64'(m_num32));
    check({tag, ".dropped"},   64'(dropped),   64'(m_dropped));
    check({tag, ".ovf"},       64'(ovf),       64'(m_ovf));
    check({tag, ".zero"},      64'(zero),      64'(m_zero));
`ifdef SL5_STICKY_OVF_EN
    check({tag, ".ovf_sticky"}, 64'(ovf_sticky), 64'(m_sticky));
`endif
  endtask

  // One clock: checks in_ready and drain order before the edge, model/outputs after.
  task automatic cyc(string tag);
    bit acc, xfer;
    logic [N-1:0] front;
    #1;
    check({tag, ".in_ready"}, 64'(in_ready), 64'(!m_valid || out_ready));
    acc  = in_valid && (!m_valid || out_ready);
    xfer = m_valid && out_ready;
    if (xfer) begin
      if (q.size() == 0) begin
        n_cmp++; n_fail++;
        $error("FAIL %s.order: got transfer expected none queued", tag);
      end else begin
        front = q.pop_front();
        check({tag, ".order"}, 64'(num32), 64'(f_shift(front)));
      end
    end
    @(posedge clk);
    #1;
    if (acc) begin
      m_valid   = 1;
      m_num32   = f_shift(num);
      m_dropped = f_drop(num);
      m_ovf     = (m_dropped != 0);
      m_zero    = (m_num32 == 0);
      q.push_back(num);
      if (m_ovf) m_sticky = 1;
      else if (ovf_clr) m_sticky = 0;
    end else begin
      if (xfer) m_valid = 0;
      if (ovf_clr) m_sticky = 0;
    end
`ifndef SL5_STICKY_OVF_EN
    m_sticky = 0;
`endif
    check_outs(tag);
  endtask

  task automatic model_reset();
    m_valid = 0; m_num32 = '0; m_dropped = '0; m_ovf = 0; m_zero = 0; m_sticky = 0;
    q.delete();
  endtask

  logic [N-1:0] t_num  [8] = '{32'h00000000, 32'h00000001, 32'h00001111, 32'h0000BEEF,
                              32'h11111111, 32'h13579BDF, 32'hF0000000, 32'hFFFFFFFF};
  logic [N-1:0] t_res  [8] = '{32'h00000000, 32'h00000020, 32'h00022220, 32'h0017DDE0,
                              32'h22222220, 32'h6AF37BE0, 32'h00000000, 32'hFFFFFFE0};
  logic [4:0]   t_drop [8] = '{5'h00, 5'h00, 5'h00, 5'h00, 5'h02, 5'h02, 5'h1E, 5'h1F};
  logic         t_ovf  [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
  logic         t_zero [8] = '{1, 0, 0, 0, 0, 0, 1, 0};

  initial begin
    // Reset state
    #3;
    model_reset();
    check_outs("rst_hold");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Streaming table, full throughput: each result one cycle after its accept
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      num = t_num[i];
      cyc("stream");
      check($sformatf("tbl%0d.num32", i),   64'(num32),   64'(t_res[i]));
      check($sformatf("tbl%0d.dropped", i), 64'(dropped), 64'(t_drop[i]));
      check($sformatf("tbl%0d.ovf", i),     64'(ovf),     64'(t_ovf[i]));
      check($sformatf("tbl%0d.zero", i),    64'(zero),    64'(t_zero[i]));
      check($sformatf("tbl%0d.valid", i),   64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    cyc("drain");

    // Backpressure
    out_ready = 1'b0;
    in_valid  = 1'b1;
    num       = 32'h00000001;
    cyc("bp_acc");
    num = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      cyc("bp_hold");
      check("bp.in_ready", 64'(in_ready), 64'd0);
      check("bp.num32", 64'(num32), 64'h20);
    end
    out_ready = 1'b1;
    cyc("bp_release");
    check("bp.new_num32", 64'(num32), 64'hFFFFFFE0);
    in_valid = 1'b0;
    cyc("bp_drain");

    // Random handshake traffic
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       num = 32'h0;
        1:       num = {5'($urandom), 27'h0};
        default: num = $urandom;
      endcase
      cyc("rand");
    end

    // Async reset mid-cycle while a result is held
    out_ready = 1'b0;
    in_valid  = 1'b1;
    num       = 32'h8000_0001;
    cyc("pre_rst");
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outs("async_rst");
    @(posedge clk); #1;
    check_outs("rst_held");
    rst_n = 1'b1;
    out_ready = 1'b1;
    cyc("post_rst");

`ifdef SL5_STICKY_OVF_EN
    in_valid = 1'b1;
    num = 32'h00000001; cyc("stk1");
    check("stk.after_none", 64'(ovf_sticky), 64'd0);
    num = 32'h80000000; cyc("stk2");
    check("stk.set", 64'(ovf_sticky), 64'd1);
    num = 32'h00000001; cyc("stk3");
    check("stk.keep", 64'(ovf_sticky), 64'd1);
    in_valid = 1'b0; ovf_clr = 1'b1; cyc("stk_clr");
    ovf_clr = 1'b0;
    check("stk.clr", 64'(ovf_sticky), 64'd0);
    in_valid = 1'b1; num = 32'hFFFFFFFF; ovf_clr = 1'b1; cyc("stk_both");
    ovf_clr = 1'b0; in_valid = 1'b0;
    check("stk.set_wins", 64'(ovf_sticky), 64'd1);
    cyc("stk_end");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
